// File: rtl/ctrl_pkg.sv
// ctrl_pkg
//   Shared definitions for the MIPS control unit: opcode/funct encodings,
//   ALU operation classes, ALU control codes, and the layout of the control
//   word carried through the E/M/W stage registers.
//   Optional feature macro: CTRL_JAL_EN (jal decode and link_* taps).
package ctrl_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation class produced by the main decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // 3-bit ALU control codes
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // Control word layout. The link bit is always present in the word; it
  // simply stays zero when jal support is not built in.
  localparam int CW_REGWRITE = 0;
  localparam int CW_REGDST   = 1;
  localparam int CW_ALUSRC   = 2;
  localparam int CW_MEMTOREG = 3;
  localparam int CW_MEMEN    = 4;
  localparam int CW_MEMWRITE = 5;
  localparam int CW_BRANCH   = 6;
  localparam int CW_LINK     = 7;
  localparam int CW_ALUC_LSB = 8;
  localparam int CW_W        = 11;

  typedef logic [CW_W-1:0] cw_t;

  localparam cw_t BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
//   Pure combinational main + ALU decoder.
//   Ports:
//     instr   in   32      instruction word
//     cw      out  CW_W    control word (all zero for an illegal instruction)
//     jump    out  1       j (and jal when CTRL_JAL_EN is defined)
//     illegal out  1       unknown opcode, or unknown funct for R-type
//   Macro CTRL_JAL_EN: when defined, opcode 000011 decodes as jal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output cw_t         cw,
  output logic        jump,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] funct;
  aluop_t     aluop;
  logic [2:0] aluc;
  cw_t        cw_raw;
  logic       jump_raw;
  logic       op_bad;
  logic       funct_bad;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  // Main decoder
  always_comb begin
    cw_raw   = BUBBLE;
    jump_raw = 1'b0;
    op_bad   = 1'b0;
    aluop    = ALUOP_ADD;
    case (op)
      OP_RTYPE: begin
        cw_raw[CW_REGWRITE] = 1'b1;
        cw_raw[CW_REGDST]   = 1'b1;
        aluop               = ALUOP_FUNCT;
      end
      OP_LW: begin
        cw_raw[CW_REGWRITE] = 1'b1;
        cw_raw[CW_ALUSRC]   = 1'b1;
        cw_raw[CW_MEMTOREG] = 1'b1;
        cw_raw[CW_MEMEN]    = 1'b1;
      end
      OP_SW: begin
        cw_raw[CW_ALUSRC]   = 1'b1;
        cw_raw[CW_MEMWRITE] = 1'b1;
        cw_raw[CW_MEMEN]    = 1'b1;
      end
      OP_BEQ: begin
        cw_raw[CW_BRANCH] = 1'b1;
        aluop             = ALUOP_SUB;
      end
      OP_ADDI: begin
        cw_raw[CW_REGWRITE] = 1'b1;
        cw_raw[CW_ALUSRC]   = 1'b1;
      end
      OP_J: jump_raw = 1'b1;
`ifdef CTRL_JAL_EN
      OP_JAL: begin
        jump_raw            = 1'b1;
        cw_raw[CW_REGWRITE] = 1'b1;
        cw_raw[CW_LINK]     = 1'b1;
      end
`endif
      default: op_bad = 1'b1;
    endcase
  end

  // ALU decoder
  always_comb begin
    aluc      = ALUC_ADD;
    funct_bad = 1'b0;
    case (aluop)
      ALUOP_ADD: aluc = ALUC_ADD;
      ALUOP_SUB: aluc = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  aluc = ALUC_ADD;
          FN_SUB:  aluc = ALUC_SUB;
          FN_AND:  aluc = ALUC_AND;
          FN_OR:   aluc = ALUC_OR;
          FN_SLT:  aluc = ALUC_SLT;
          default: begin
            aluc      = ALUC_AND;
            funct_bad = 1'b1;
          end
        endcase
      end
      default: aluc = ALUC_ADD;
    endcase
  end

  // An illegal instruction yields the all-zero control word so it can never
  // cause a side effect, whether or not it is later turned into a bubble.
  always_comb begin
    illegal = op_bad | funct_bad;
    cw      = cw_raw;
    cw[CW_ALUC_LSB +: 3] = aluc;
    jump    = jump_raw;
    if (illegal) begin
      cw   = BUBBLE;
      jump = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit
//   MIPS control unit with a stage-tracked control pipeline. Decodes instr_d
//   in D and carries the control word through E, M and W registers, each
//   with its own valid bit and stall/flush handling.
//   Ports:
//     clka, rst (sync, active low)
//     instr_d                      decode-stage instruction
//     stall_e, flush_e             E hold / bubble
//     stall_m, flush_m             M hold (also holds E) / bubble
//     flush_w                      W bubble
//     jump_d, illegal_d            combinational D decode
//     valid_e/m/w                  stage holds a real instruction
//     regdst_e, alusrc_e, regwrite_e, memtoreg_e, alucontrol_e
//     branch_m, memwrite_m, memen_m, regwrite_m, memtoreg_m
//     regwrite_w, memtoreg_w
//     link_e/m/w                   only when CTRL_JAL_EN is defined
//   Parameters: ALUC_W (alucontrol width, >=3), ILLEGAL_BUBBLE.
//   Macro CTRL_JAL_EN: enables jal decode and the link_* taps.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int ALUC_W         = 3,
  parameter bit ILLEGAL_BUBBLE = 1'b1
) (
  input  logic              clka,
  input  logic              rst,
  input  logic [31:0]       instr_d,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              stall_m,
  input  logic              flush_m,
  input  logic              flush_w,
  output logic              jump_d,
  output logic              illegal_d,
  output logic              valid_e,
  output logic              valid_m,
  output logic              valid_w,
  output logic              regdst_e,
  output logic              alusrc_e,
  output logic              regwrite_e,
  output logic              memtoreg_e,
  output logic [ALUC_W-1:0] alucontrol_e,
  output logic              branch_m,
  output logic              memwrite_m,
  output logic              memen_m,
  output logic              regwrite_m,
  output logic              memtoreg_m,
  output logic              regwrite_w,
  output logic              memtoreg_w
`ifdef CTRL_JAL_EN
  ,
  output logic              link_e,
  output logic              link_m,
  output logic              link_w
`endif
);

  cw_t  cw_d;
  cw_t  cw_d_entry;
  logic valid_d_entry;

  cw_t  cw_e_reg, cw_m_reg, cw_w_reg;
  logic valid_e_reg, valid_m_reg, valid_w_reg;

  ctrl_decode u_decode (
    .instr   (instr_d),
    .cw      (cw_d),
    .jump    (jump_d),
    .illegal (illegal_d)
  );

  // What E would load from D this cycle.
  always_comb begin
    cw_d_entry    = cw_d;
    valid_d_entry = 1'b1;
    if (illegal_d && ILLEGAL_BUBBLE) begin
      cw_d_entry    = BUBBLE;
      valid_d_entry = 1'b0;
    end
  end

  // E stage: a stall in M must also freeze E so nothing is overwritten.
  always_ff @(posedge clka) begin
    if (!rst) begin
      cw_e_reg    <= BUBBLE;
      valid_e_reg <= 1'b0;
    end else if (flush_e) begin
      cw_e_reg    <= BUBBLE;
      valid_e_reg <= 1'b0;
    end else if (!(stall_e || stall_m)) begin
      cw_e_reg    <= cw_d_entry;
      valid_e_reg <= valid_d_entry;
    end
  end

  // M stage: when only E is stalled, M drains and takes a bubble.
  always_ff @(posedge clka) begin
    if (!rst) begin
      cw_m_reg    <= BUBBLE;
      valid_m_reg <= 1'b0;
    end else if (flush_m) begin
      cw_m_reg    <= BUBBLE;
      valid_m_reg <= 1'b0;
    end else if (stall_m) begin
      cw_m_reg    <= cw_m_reg;
      valid_m_reg <= valid_m_reg;
    end else if (stall_e) begin
      cw_m_reg    <= BUBBLE;
      valid_m_reg <= 1'b0;
    end else begin
      cw_m_reg    <= cw_e_reg;
      valid_m_reg <= valid_e_reg;
    end
  end

  // W stage never holds; a stalled M feeds it a bubble.
  always_ff @(posedge clka) begin
    if (!rst) begin
      cw_w_reg    <= BUBBLE;
      valid_w_reg <= 1'b0;
    end else if (flush_w || stall_m) begin
      cw_w_reg    <= BUBBLE;
      valid_w_reg <= 1'b0;
    end else begin
      cw_w_reg    <= cw_m_reg;
      valid_w_reg <= valid_m_reg;
    end
  end

  assign valid_e = valid_e_reg;
  assign valid_m = valid_m_reg;
  assign valid_w = valid_w_reg;

  assign regdst_e   = cw_e_reg[CW_REGDST];
  assign alusrc_e   = cw_e_reg[CW_ALUSRC];
  assign regwrite_e = cw_e_reg[CW_REGWRITE] & valid_e_reg;
  assign memtoreg_e = cw_e_reg[CW_MEMTOREG];

  // Zero-extend the 3-bit code to the configured width.
  always_comb begin
    alucontrol_e      = '0;
    alucontrol_e[2:0] = cw_e_reg[CW_ALUC_LSB +: 3];
  end

  // Side-effect controls are qualified by valid so a non-real slot is inert.
  assign branch_m   = cw_m_reg[CW_BRANCH] & valid_m_reg;
  assign memwrite_m = cw_m_reg[CW_MEMWRITE] & valid_m_reg;
  assign memen_m    = cw_m_reg[CW_MEMEN] & valid_m_reg;
  assign regwrite_m = cw_m_reg[CW_REGWRITE] & valid_m_reg;
  assign memtoreg_m = cw_m_reg[CW_MEMTOREG];

  assign regwrite_w = cw_w_reg[CW_REGWRITE] & valid_w_reg;
  assign memtoreg_w = cw_w_reg[CW_MEMTOREG];

`ifdef CTRL_JAL_EN
  assign link_e = cw_e_reg[CW_LINK] & valid_e_reg;
  assign link_m = cw_m_reg[CW_LINK] & valid_m_reg;
  assign link_w = cw_w_reg[CW_LINK] & valid_w_reg;
`endif

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb_ctrl_pipe_unit
//   Directed self-checking bench for ctrl_pipe_unit (ALUC_W=4 to exercise the
//   zero extension, ILLEGAL_BUBBLE=1). Handles CTRL_JAL_EN both ways.
module tb_ctrl_pipe_unit;
  localparam int ALUC_W = 4;

  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_SUB  = 32'h00221822;
  localparam logic [31:0] I_SLT  = 32'h0022182A;
  localparam logic [31:0] I_SW   = 32'hAC220008;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_BAD  = 32'h0000003F;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_J    = 32'h08000000;
  localparam logic [31:0] I_ADDI = 32'h20220005;
  localparam logic [31:0] I_NOP  = 32'h00000000;

  logic              clka = 1'b0;
  logic              rst = 1'b0;
  logic [31:0]       instr_d = '0;
  logic              stall_e = 1'b0, flush_e = 1'b0, stall_m = 1'b0;
  logic              flush_m = 1'b0, flush_w = 1'b0;
  logic              jump_d, illegal_d, valid_e, valid_m, valid_w;
  logic              regdst_e, alusrc_e, regwrite_e, memtoreg_e;
  logic [ALUC_W-1:0] alucontrol_e;
  logic              branch_m, memwrite_m, memen_m, regwrite_m, memtoreg_m;
  logic              regwrite_w, memtoreg_w;
`ifdef CTRL_JAL_EN
  logic              link_e, link_m, link_w;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clka = ~clka;

  ctrl_pipe_unit #(.ALUC_W(ALUC_W), .ILLEGAL_BUBBLE(1'b1)) dut (
    .clka(clka), .rst(rst), .instr_d(instr_d),
    .stall_e(stall_e), .flush_e(flush_e), .stall_m(stall_m),
    .flush_m(flush_m), .flush_w(flush_w),
    .jump_d(jump_d), .illegal_d(illegal_d),
    .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
    .regdst_e(regdst_e), .alusrc_e(alusrc_e), .regwrite_e(regwrite_e),
    .memtoreg_e(memtoreg_e), .alucontrol_e(alucontrol_e),
    .branch_m(branch_m), .memwrite_m(memwrite_m), .memen_m(memen_m),
    .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
    .regwrite_w(regwrite_w), .memtoreg_w(memtoreg_w)
`ifdef CTRL_JAL_EN
    , .link_e(link_e), .link_m(link_m), .link_w(link_w)
`endif
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clka);
    #1;
  endtask

  function automatic logic [18:0] all_regs();
    return {valid_e, valid_m, valid_w, regdst_e, alusrc_e, regwrite_e,
            memtoreg_e, alucontrol_e, branch_m, memwrite_m, memen_m,
            regwrite_m, memtoreg_m, regwrite_w, memtoreg_w};
  endfunction

  task automatic test_reset();
    logic [18:0] obs;
    rst = 1'b0; instr_d = I_LW;
    step(); step();
    obs = all_regs();
    checks++;
    if (obs !== 19'h0) begin
      errors++; $display("FAIL reset_regs got %h want 00000", obs);
    end
    checks++;
    if ({jump_d, illegal_d} !== 2'b00) begin
      errors++; $display("FAIL reset_decode got %b want 00", {jump_d, illegal_d});
    end
    instr_d = I_NOP; rst = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_lw();
    instr_d = I_LW; step();
    checks++;
    if ({valid_e, alusrc_e, memtoreg_e, alucontrol_e} !== {1'b1, 1'b1, 1'b1, 4'b0010}) begin
      errors++; $display("FAIL lw_e got %b want 1110010", {valid_e, alusrc_e, memtoreg_e, alucontrol_e});
    end
    instr_d = I_NOP; step();
    checks++;
    if ({valid_m, memen_m, memwrite_m, regwrite_m} !== 4'b1101) begin
      errors++; $display("FAIL lw_m got %b want 1101", {valid_m, memen_m, memwrite_m, regwrite_m});
    end
    checks++;
    if (valid_e !== 1'b0) begin
      errors++; $display("FAIL nop_bubble_e got %b want 0", valid_e);
    end
    step();
    checks++;
    if ({valid_w, regwrite_w, memtoreg_w} !== 3'b111) begin
      errors++; $display("FAIL lw_w got %b want 111", {valid_w, regwrite_w, memtoreg_w});
    end
    $display("test_lw done");
  endtask

  task automatic test_back_to_back();
    instr_d = I_ADD; step();
    checks++;
    if ({regdst_e, regwrite_e, alucontrol_e} !== 6'b11_0010) begin
      errors++; $display("FAIL add_e got %b want 110010", {regdst_e, regwrite_e, alucontrol_e});
    end
    instr_d = I_SUB; step();
    checks++;
    if (alucontrol_e !== 4'b0110) begin
      errors++; $display("FAIL sub_aluc got %b want 0110", alucontrol_e);
    end
    instr_d = I_SLT; step();
    checks++;
    if (alucontrol_e !== 4'b0111) begin
      errors++; $display("FAIL slt_aluc got %b want 0111", alucontrol_e);
    end
    instr_d = I_ADDI; step();
    checks++;
    if ({regdst_e, alusrc_e, regwrite_e, alucontrol_e} !== 7'b011_0010) begin
      errors++; $display("FAIL addi_e got %b want 0110010", {regdst_e, alusrc_e, regwrite_e, alucontrol_e});
    end
    instr_d = I_NOP;
    $display("test_back_to_back done");
  endtask

  task automatic test_stall_e();
    instr_d = I_SW; step();
    instr_d = I_NOP; stall_e = 1'b1; step();
    checks++;
    if ({valid_e, alusrc_e, valid_m, memwrite_m} !== 4'b1100) begin
      errors++; $display("FAIL stall_e_hold got %b want 1100", {valid_e, alusrc_e, valid_m, memwrite_m});
    end
    stall_e = 1'b0; step();
    checks++;
    if ({valid_m, memwrite_m, memen_m, regwrite_m} !== 4'b1110) begin
      errors++; $display("FAIL sw_m got %b want 1110", {valid_m, memwrite_m, memen_m, regwrite_m});
    end
    $display("test_stall_e done");
  endtask

  task automatic test_stall_flush_m();
    instr_d = I_BEQ; step();
    checks++;
    if ({valid_e, alucontrol_e} !== 5'b1_0110) begin
      errors++; $display("FAIL beq_e got %b want 10110", {valid_e, alucontrol_e});
    end
    instr_d = I_NOP; step();
    checks++;
    if ({valid_m, branch_m} !== 2'b11) begin
      errors++; $display("FAIL beq_m got %b want 11", {valid_m, branch_m});
    end
    stall_m = 1'b1; flush_m = 1'b1; step();
    checks++;
    if ({valid_m, branch_m, valid_w} !== 3'b000) begin
      errors++; $display("FAIL stall_flush_m got %b want 000", {valid_m, branch_m, valid_w});
    end
    stall_m = 1'b0; flush_m = 1'b0;
    $display("test_stall_flush_m done");
  endtask

  task automatic test_flush_e_w();
    instr_d = I_LW; step();
    instr_d = I_ADDI; flush_e = 1'b1; step();
    checks++;
    if ({valid_e, alusrc_e, regwrite_e, valid_m, memen_m} !== 5'b00011) begin
      errors++; $display("FAIL flush_e got %b want 00011", {valid_e, alusrc_e, regwrite_e, valid_m, memen_m});
    end
    flush_e = 1'b0; flush_w = 1'b1; instr_d = I_NOP; step();
    checks++;
    if ({valid_w, regwrite_w, memtoreg_w, valid_m} !== 4'b0000) begin
      errors++; $display("FAIL flush_w got %b want 0000", {valid_w, regwrite_w, memtoreg_w, valid_m});
    end
    flush_w = 1'b0;
    $display("test_flush_e_w done");
  endtask

  task automatic test_midreset();
    logic [18:0] obs;
    instr_d = I_LW; step();
    instr_d = I_ADD; step();
    rst = 1'b0; step();
    obs = all_regs();
    checks++;
    if (obs !== 19'h0) begin
      errors++; $display("FAIL midreset got %h want 00000", obs);
    end
    rst = 1'b1; instr_d = I_SUB; step();
    checks++;
    if ({valid_e, alucontrol_e, valid_m, valid_w} !== 7'b1_0110_00) begin
      errors++; $display("FAIL reset_release got %b want 1011000", {valid_e, alucontrol_e, valid_m, valid_w});
    end
    instr_d = I_NOP;
    $display("test_midreset done");
  endtask

  task automatic test_illegal_jump();
    instr_d = I_BAD; #1;
    checks++;
    if ({illegal_d, jump_d} !== 2'b10) begin
      errors++; $display("FAIL illegal_funct got %b want 10", {illegal_d, jump_d});
    end
    step();
    checks++;
    if ({valid_e, regwrite_e} !== 2'b00) begin
      errors++; $display("FAIL illegal_bubble got %b want 00", {valid_e, regwrite_e});
    end
    instr_d = I_J; #1;
    checks++;
    if ({illegal_d, jump_d} !== 2'b01) begin
      errors++; $display("FAIL j_decode got %b want 01", {illegal_d, jump_d});
    end
    instr_d = I_JAL; #1;
`ifdef CTRL_JAL_EN
    checks++;
    if ({illegal_d, jump_d} !== 2'b01) begin
      errors++; $display("FAIL jal_decode got %b want 01", {illegal_d, jump_d});
    end
    step();
    instr_d = I_NOP; step(); step();
    checks++;
    if ({link_w, regwrite_w, valid_w} !== 3'b111) begin
      errors++; $display("FAIL jal_w got %b want 111", {link_w, regwrite_w, valid_w});
    end
`else
    checks++;
    if ({illegal_d, jump_d} !== 2'b10) begin
      errors++; $display("FAIL jal_illegal got %b want 10", {illegal_d, jump_d});
    end
    step();
    checks++;
    if (valid_e !== 1'b0) begin
      errors++; $display("FAIL jal_bubble got %b want 0", valid_e);
    end
`endif
    instr_d = I_NOP;
    $display("test_illegal_jump done");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_stall_e();
    test_stall_flush_m();
    test_flush_e_w();
    test_midreset();
    test_illegal_jump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
